// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: handshake/data bundle for fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] din;
  logic             we;
  logic             re;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    cnt;
  logic             overflow;
  logic             underflow;
  logic             parity_err;

  modport master (
    output din,
    output we,
    output re,
    output clr_err,
    input  dout,
    input  rd_valid,
    input  empty,
    input  full,
    input  almost_empty,
    input  almost_full,
    input  cnt,
    input  overflow,
    input  underflow,
    input  parity_err
  );

  modport slave (
    input  din,
    input  we,
    input  re,
    input  clr_err,
    output dout,
    output rd_valid,
    output empty,
    output full,
    output almost_empty,
    output almost_full,
    output cnt,
    output overflow,
    output underflow,
    output parity_err
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with threshold
// flags, sticky overflow/underflow and a read-data valid strobe.
// Optional macro FIFO_PARITY_EN: each entry carries an even-parity
// bit; parity_err pulses with rd_valid on a mismatch (else tied 0).
// Ports: clk, rst (sync, active-high), bus (fifo_sync_param_if.slave)
//   in : din, we, re, clr_err
//   out: dout, rd_valid, empty, full, almost_empty, almost_full,
//        cnt, overflow, underflow, parity_err
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  fifo_sync_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
`ifdef FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [MW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             perr_q, perr_d;

  logic             empty;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    rd_word;

  // Status comes from the occupancy count only.
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_C);

  // Acceptance uses pre-edge status: no write-through when full,
  // no bypass of write data when empty.
  assign wr_ok = bus.we & ~full;
  assign rd_ok = bus.re & ~empty;

  assign rd_word = mem_q[rptr_q];

`ifdef FIFO_PARITY_EN
  assign wr_word = {^bus.din, bus.din};
`else
  assign wr_word = bus.din;
`endif

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    rd_valid_d = rd_ok;
    perr_d     = 1'b0;

    // Pointers are exactly log2(DEPTH) wide, so +1 wraps.
    if (wr_ok) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + PW'(1);
      dout_d = rd_word[WIDTH-1:0];
`ifdef FIFO_PARITY_EN
      // Stored bit makes the entry even; any odd word is corrupt.
      perr_d = ^rd_word;
`endif
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A new error in the clearing cycle still sets the flag.
    ovf_d = (bus.we & full) | (ovf_q & ~bus.clr_err);
    udf_d = (bus.re & empty) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      perr_q     <= perr_d;
    end
  end

  // Storage is not reset; a write during reset is discarded.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem_q[wptr_q] <= wr_word;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (cnt_q <= AE_C);
  assign bus.almost_full  = (cnt_q >= AF_C);
  assign bus.cnt          = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.parity_err   = perr_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed, table-driven and random checks of
// fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         qp[$];
  logic [7:0] m_dout;
  bit         m_rv, m_ovf, m_udf, m_perr;

  typedef struct {
    logic [7:0] din;
    int         cnt;
    bit         ae;
    bit         af;
    bit         fl;
  } vec_t;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", n, act, exp, $time);
    end
  endfunction

  task automatic model(bit r, bit w, bit rd, bit c, logic [7:0] d);
    bit fl, em;
    if (r) begin
      q.delete();
      qp.delete();
      m_dout = 8'h00;
      m_rv   = 0;
      m_ovf  = 0;
      m_udf  = 0;
      m_perr = 0;
      return;
    end
    fl     = (q.size() == DEPTH);
    em     = (q.size() == 0);
    m_rv   = rd && !em;
    m_perr = 0;
    if (rd && !em) begin
      m_dout = q.pop_front();
      m_perr = qp.pop_front();
    end
    if (w && !fl) begin
      q.push_back(d);
      qp.push_back(1'b0);
    end
    m_ovf = (w && fl) || (m_ovf && !c);
    m_udf = (rd && em) || (m_udf && !c);
  endtask

  task automatic compare();
    chk("cnt", bus.cnt, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == DEPTH);
    chk("almost_empty", bus.almost_empty, q.size() <= AE);
    chk("almost_full", bus.almost_full, q.size() >= AF);
    chk("rd_valid", bus.rd_valid, m_rv);
    chk("dout", bus.dout, m_dout);
    chk("overflow", bus.overflow, m_ovf);
    chk("underflow", bus.underflow, m_udf);
    chk("parity_err", bus.parity_err, m_perr);
  endtask

  task automatic cyc(bit r, bit w, bit rd, bit c, logic [7:0] d);
    rst         = r;
    bus.we      = w;
    bus.re      = rd;
    bus.clr_err = c;
    bus.din     = d;
    @(posedge clk);
    model(r, w, rd, c, d);
    #1;
    compare();
  endtask

  vec_t       tbl[16];
  logic [7:0] exp_q[$];
  logic [7:0] head;

  initial begin
    tbl = '{
      '{8'h21,  1, 1, 0, 0},
      '{8'h22,  2, 1, 0, 0},
      '{8'h23,  3, 0, 0, 0},
      '{8'h24,  4, 0, 0, 0},
      '{8'h25,  5, 0, 0, 0},
      '{8'h26,  6, 0, 0, 0},
      '{8'h27,  7, 0, 0, 0},
      '{8'h28,  8, 0, 0, 0},
      '{8'h29,  9, 0, 0, 0},
      '{8'h2A, 10, 0, 0, 0},
      '{8'h2B, 11, 0, 0, 0},
      '{8'h2C, 12, 0, 0, 0},
      '{8'h2D, 13, 0, 0, 0},
      '{8'h2E, 14, 0, 1, 0},
      '{8'h2F, 15, 0, 1, 0},
      '{8'h30, 16, 0, 1, 1}
    };

    // Reset state.
    cyc(1, 0, 0, 0, 8'h00);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_empty", bus.empty, 1);

    // Fill 0x01..0x10, then read back in order.
    for (int i = 1; i <= 16; i++) cyc(0, 1, 0, 0, 8'(i));
    chk("t1_full", bus.full, 1);
    chk("t1_cnt", bus.cnt, 16);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 0, 8'h00);
      chk("t1_dout", bus.dout, i);
      chk("t1_rv", bus.rd_valid, 1);
    end
    cyc(0, 0, 0, 0, 8'h00);
    chk("t1_rv_low", bus.rd_valid, 0);
    chk("t1_empty", bus.empty, 1);

    // Threshold table, one word at a time from empty.
    cyc(1, 0, 0, 0, 8'h00);
    chk("t2_ae0", bus.almost_empty, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0, tbl[i].din);
      chk("t2_cnt", bus.cnt, tbl[i].cnt);
      chk("t2_ae", bus.almost_empty, tbl[i].ae);
      chk("t2_af", bus.almost_full, tbl[i].af);
      chk("t2_full", bus.full, tbl[i].fl);
    end
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 8'h00);

    // Simultaneous traffic across the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 8'(8'h51 + i));
      exp_q.push_back(8'(8'h51 + i));
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, 0, 8'(8'hA0 + i));
      exp_q.push_back(8'(8'hA0 + i));
      chk("t3_cnt", bus.cnt, 5);
      chk("t3_dout", bus.dout, exp_q.pop_front());
    end

    // Full with we & re.
    for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, 8'(8'hC0 + i));
    chk("t4_full", bus.full, 1);
    head = q[0];
    cyc(0, 1, 1, 0, 8'hEE);
    chk("t4_f_dout", bus.dout, head);
    chk("t4_f_cnt", bus.cnt, 15);
    chk("t4_f_ovf", bus.overflow, 1);
    chk("t4_f_rv", bus.rd_valid, 1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 8'h00);

    // Empty with we & re.
    cyc(0, 1, 1, 0, 8'h3C);
    chk("t4_e_cnt", bus.cnt, 1);
    chk("t4_e_udf", bus.underflow, 1);
    chk("t4_e_rv", bus.rd_valid, 0);
    cyc(0, 0, 0, 1, 8'h00);
    chk("t4_clr_ovf", bus.overflow, 0);
    chk("t4_clr_udf", bus.underflow, 0);
    cyc(0, 0, 1, 0, 8'h00);
    chk("t4_e_dout", bus.dout, 8'h3C);
    // New underflow in the clearing cycle wins.
    cyc(0, 0, 1, 1, 8'h00);
    chk("t4_setwins", bus.underflow, 1);
    cyc(0, 0, 0, 1, 8'h00);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 8'(8'h61 + i));
    cyc(0, 1, 1, 0, 8'h68);
    cyc(1, 1, 0, 0, 8'hFF);
    chk("t5_cnt", bus.cnt, 0);
    chk("t5_empty", bus.empty, 1);
    chk("t5_dout", bus.dout, 0);
    chk("t5_rv", bus.rd_valid, 0);
    cyc(0, 1, 0, 0, 8'h77);
    cyc(0, 0, 1, 0, 8'h00);
    chk("t5_new", bus.dout, 8'h77);

`ifdef FIFO_PARITY_EN
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h5A);
    cyc(0, 1, 0, 0, 8'h33);
    dut.mem_q[0][0] = ~dut.mem_q[0][0];
    q[0]  = q[0] ^ 8'h01;
    qp[0] = 1'b1;
    cyc(0, 0, 1, 0, 8'h00);
    chk("t6_rv", bus.rd_valid, 1);
    chk("t6_perr", bus.parity_err, 1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("t6_clean", bus.parity_err, 0);
    chk("t6_dout", bus.dout, 8'h33);
`endif

    // Random traffic against the queue model.
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 256) == 0,
          ($urandom % 10) < 6,
          ($urandom % 10) < 5,
          ($urandom % 16) == 0,
          8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
